// File: rtl/sakebi_pkg.sv
// Shared RMII constants, FSM encoding and CRC helpers for the sakebi TX/RX pair.
// Latency: n/a (package only).
// Backpressure: n/a.
package sakebi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_FCS      = 3'd4,
        ST_IFG      = 3'd5
    } tx_state_t;

    localparam int          PREAMBLE_DIBITS = 28;
    localparam int          SFD_DIBITS      = 4;
    localparam int          FCS_DIBITS      = 16;
    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    // Bit-reverse a 32-bit word; turns the normal-form polynomial into the
    // LSB-first form used by the Ethernet FCS.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sakebi_rmii_tx_if.sv
// Bundle of the AXI-Stream byte source and RMII transmit pins around sakebi_rmii_tx.
// Latency: n/a (wires only).
// Backpressure: tready from the transmitter gates tvalid/tdata/tlast from the source.
// master = byte source / PHY-side observer, slave = transmitter.
interface sakebi_rmii_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tx_en;
    logic [1:0]            txd;
    logic                  underrun;

    modport master (
        output tvalid, tdata, tlast,
        input  tready, tx_en, txd, underrun
    );

    modport slave (
        input  tvalid, tdata, tlast,
        output tready, tx_en, txd, underrun
    );
endinterface

// File: rtl/sakebi_crc32.sv
// Byte-wise Ethernet CRC-32 update (reflected, LSB of the byte first).
// Latency: combinational.
// Backpressure: none; caller decides when to register o_crc.
// Ports: i_crc running remainder, i_data next byte, o_crc updated remainder.
module sakebi_crc32 (
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);
    import sakebi_pkg::*;

    localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_crc[0] ^ i_data[i]) begin
                w_crc = (w_crc >> 1) ^ POLY_REFL;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
    end

    assign o_crc = w_crc;

endmodule

// File: rtl/sakebi_rmii_tx.sv
// AXI-Stream byte source to 100 Mb/s RMII transmitter with preamble/SFD, optional FCS and IFG.
// Latency: TVALID seen in IDLE -> TX_EN high the next cycle; bytes leave as 4 dibits LSB first.
// Backpressure: TREADY pulses once per byte (last SFD cycle, then dibit 3 of each non-last byte).
// Ports: i_axis_ACLK (50 MHz ref clock), i_axis_ARESETn (async, active low), AXI-Stream
//        TVALID/TREADY/TDATA/TLAST in, RMII TX_EN/TXD out, o_underrun starvation pulse.
// Build option: define SAKEBI_RMII_TX_FCS_EN to append a computed CRC-32 FCS; without it the
//        source must supply the FCS as the last 4 bytes of the frame.
module sakebi_rmii_tx #(
    parameter int DATA_WIDTH = 8,   // only 8 is supported
    parameter int IFG_CYCLES = 48
) (
    input  logic                  i_axis_ACLK,
    input  logic                  i_axis_ARESETn,
    input  logic                  i_axis_TVALID,
    output logic                  o_axis_TREADY,
    input  logic [DATA_WIDTH-1:0] i_axis_TDATA,
    input  logic                  i_axis_TLAST,
    output logic                  o_rmii_TX_EN,
    output logic [1:0]            o_rmii_TXD,
    output logic                  o_underrun
);
    import sakebi_pkg::*;

    // One shared counter sized for the longest state (IFG or preamble).
    localparam int CNT_MAX = (IFG_CYCLES > PREAMBLE_DIBITS) ? IFG_CYCLES - 1 : PREAMBLE_DIBITS - 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_PRE_LAST = CNT_W'(PREAMBLE_DIBITS - 1);
    localparam logic [CNT_W-1:0] C_SFD_LAST = CNT_W'(SFD_DIBITS - 1);
    localparam logic [CNT_W-1:0] C_DIB_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] C_IFG_LAST = CNT_W'(IFG_CYCLES - 1);

    tx_state_t             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_byte;
    logic                  r_last;
    logic                  r_tx_en;
    logic [1:0]            r_txd;
    logic                  r_underrun;

    tx_state_t             w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_load;
    logic                  w_underrun_nxt;
    logic [DATA_WIDTH-1:0] w_byte_nxt;
    logic                  w_tx_en_nxt;
    logic [1:0]            w_txd_nxt;

`ifdef SAKEBI_RMII_TX_FCS_EN
    localparam logic [CNT_W-1:0] C_FCS_LAST = CNT_W'(FCS_DIBITS - 1);

    logic [31:0] r_crc;
    logic [31:0] w_crc_nxt;
    logic [31:0] w_fcs;

    sakebi_crc32 u_crc32 (
        .i_crc  (r_crc),
        .i_data (i_axis_TDATA),
        .o_crc  (w_crc_nxt)
    );

    assign w_fcs = ~r_crc;

    // Restart at every frame start; fold in each byte at its handshake so the
    // remainder is complete before the FCS state is entered.
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            r_crc <= CRC32_INIT;
        end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_PREAMBLE)) begin
            r_crc <= CRC32_INIT;
        end else if (w_load) begin
            r_crc <= w_crc_nxt;
        end
    end
`endif

    // State register
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_load         = 1'b0;
        w_underrun_nxt = 1'b0;
        w_cnt_inc      = r_cnt + C_ONE;
        case (r_state)
            ST_IDLE: begin
                // The waiting byte is only looked at here, not consumed.
                if (i_axis_TVALID) begin
                    w_state_nxt = ST_PREAMBLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PREAMBLE: begin
                if (r_cnt == C_PRE_LAST) begin
                    w_state_nxt = ST_SFD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_SFD: begin
                if (r_cnt == C_SFD_LAST) begin
                    w_cnt_nxt = '0;
                    if (i_axis_TVALID) begin
                        w_state_nxt = ST_DATA;
                        w_load      = 1'b1;
                    end else begin
                        // Source withdrew before the first byte: treat as starvation.
                        w_state_nxt    = ST_IFG;
                        w_underrun_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_DATA: begin
                if (r_cnt == C_DIB_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_last) begin
`ifdef SAKEBI_RMII_TX_FCS_EN
                        w_state_nxt = ST_FCS;
`else
                        w_state_nxt = ST_IFG;
`endif
                    end else if (i_axis_TVALID) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt    = ST_IFG;
                        w_underrun_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
`ifdef SAKEBI_RMII_TX_FCS_EN
            ST_FCS: begin
                if (r_cnt == C_FCS_LAST) begin
                    w_state_nxt = ST_IFG;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
`endif
            ST_IFG: begin
                if (r_cnt == C_IFG_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_byte_nxt = w_load ? i_axis_TDATA : r_byte;

    // Output logic: pin values are computed for the upcoming state so that the
    // registered pins line up with r_state in the same cycle.
    always_comb begin
        w_tx_en_nxt = 1'b0;
        w_txd_nxt   = 2'b00;
        case (w_state_nxt)
            ST_PREAMBLE: begin
                w_tx_en_nxt = 1'b1;
                w_txd_nxt   = 2'b01;
            end
            ST_SFD: begin
                w_tx_en_nxt = 1'b1;
                w_txd_nxt   = (w_cnt_nxt == C_SFD_LAST) ? 2'b11 : 2'b01;
            end
            ST_DATA: begin
                w_tx_en_nxt = 1'b1;
                w_txd_nxt   = w_byte_nxt[{w_cnt_nxt[1:0], 1'b0} +: 2];
            end
`ifdef SAKEBI_RMII_TX_FCS_EN
            ST_FCS: begin
                w_tx_en_nxt = 1'b1;
                w_txd_nxt   = w_fcs[{w_cnt_nxt[3:0], 1'b0} +: 2];
            end
`endif
            default: begin
                w_tx_en_nxt = 1'b0;
                w_txd_nxt   = 2'b00;
            end
        endcase
    end

    // TREADY depends only on registers, never on TVALID.
    assign o_axis_TREADY = ((r_state == ST_SFD)  && (r_cnt == C_SFD_LAST)) ||
                           ((r_state == ST_DATA) && (r_cnt == C_DIB_LAST) && !r_last);

    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            r_byte     <= '0;
            r_last     <= 1'b0;
            r_tx_en    <= 1'b0;
            r_txd      <= 2'b00;
            r_underrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_byte <= i_axis_TDATA;
                r_last <= i_axis_TLAST;
            end
            r_tx_en    <= w_tx_en_nxt;
            r_txd      <= w_txd_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    assign o_rmii_TX_EN = r_tx_en;
    assign o_rmii_TXD   = r_txd;
    assign o_underrun   = r_underrun;

endmodule
